// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter sharing one uart_tx between byte-stream requesters
module uart_tx_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         MAX_BURST   = 16,
    parameter logic [7:0] GAP_TIMEOUT = 8'd255
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 gap_abort_o
);

    localparam int         IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] GAP_LAST   = GAP_TIMEOUT - 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          last_q, last_d;
    logic [7:0]    burst_cnt_q, burst_cnt_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic          gap_abort_q, gap_abort_d;

    logic [IW-1:0] pick;
    logic          found;
    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IW'(s);
    endfunction

    // Search starts just past the previous owner, so the previous owner has lowest priority.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_valid_i[wrap_idx(ptr_q, i)]) begin
                found = 1'b1;
                pick  = wrap_idx(ptr_q, i);
            end
        end
    end

    always_comb begin
        sel_valid = req_valid_i[owner_q];
        sel_last  = req_last_i[owner_q];
        sel_data  = req_data_i[{owner_q, 3'b000} +: 8];
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        gap_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d     = pick;
                    burst_cnt_d = '0;
                    gap_cnt_d   = '0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sel_valid) begin
                    tx_data_d  = sel_data;
                    tx_valid_d = 1'b1;
                    last_d     = sel_last;
                    gap_cnt_d  = '0;
                    state_d    = ST_ACK;
                end else if (gap_cnt_q == GAP_LAST) begin
                    gap_abort_d = 1'b1;
                    ptr_d       = owner_q;
                    gap_cnt_d   = '0;
                    burst_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else if (gap_cnt_q != 8'hFF) begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            ST_ACK: begin
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    // A last byte landing on the burst limit releases only once.
                    if (last_q || (burst_cnt_q == BURST_LAST)) begin
                        burst_cnt_d = '0;
                        ptr_d       = owner_q;
                        state_d     = ST_IDLE;
                    end else begin
                        if (burst_cnt_q != 8'hFF) begin
                            burst_cnt_d = burst_cnt_q + 8'd1;
                        end
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= IW'(NUM_REQ - 1);
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            last_q      <= 1'b0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            gap_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_abort_q <= gap_abort_d;
        end
    end

    always_comb begin
        grant_o     = (state_q != ST_IDLE) ? (NUM_REQ'(1) << owner_q) : '0;
        req_ready_o = (state_q == ST_SEND) ? grant_o : '0;
        busy_o      = (state_q != ST_IDLE);
        tx_data_o   = tx_data_q;
        tx_valid_o  = tx_valid_q;
        gap_abort_o = gap_abort_q;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, such as the APB bridge, a debug port and a DMA.
- Round-robin arbitration with packet locking: a granted requester keeps the transmitter until it sends its last byte, hits the burst limit, or stalls past a gap timeout.
- Sits between the requesters and the uart_tx instance, driving its tx_data/tx_valid inputs and observing its tx_ready output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration (1..255).
- GAP_TIMEOUT, 8'd255, cycles a granted requester may hold req_valid low mid-packet before the grant is revoked (1..255).

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RSTN  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_last_i  in  NUM_REQ  byte is the last of the packet; qualified by valid.
- req_ready_o  out  NUM_REQ  byte accepted when valid&ready on the same edge.
- tx_data_o  out  8  byte to uart_tx.
- tx_valid_o  out  1  byte valid to uart_tx.
- tx_ready_i  in  1  uart_tx accepts the byte when tx_valid_o&tx_ready_i.
- grant_o  out  NUM_REQ  one-hot current owner; all zero in IDLE.
- busy_o  out  1  high whenever state != IDLE.
- gap_abort_o  out  1  one-cycle pulse when the grant is revoked by timeout.

Behaviour:
- Reset (RSTN low, asynchronous):
  - state=IDLE; tx_valid_o=0, tx_data_o=0, grant_o=0, gap_abort_o=0, burst_cnt=0, gap_cnt=0.
  - RR pointer resets so that requester 0 has highest priority.
  - An in-flight byte is dropped. No req_ready_o is asserted while RSTN is low.
- FSM states: IDLE, SEND, ACK.
- IDLE:
  - If any req_valid_i is set, register a grant to the first valid index searching upward from (last_grant+1) mod NUM_REQ, then go to SEND.
  - Arbitration latency is 1 cycle: grant_o is visible the cycle after the request is seen.
  - With no valid requests, remain in IDLE.
- SEND:
  - req_ready_o = grant_o, combinational; the other requesters' ready bits are 0.
  - On valid&ready of the granted requester:
    - latch the byte into tx_data_o; set tx_valid_o=1 next cycle;
    - capture last; clear gap_cnt; go to ACK.
  - Without valid: gap_cnt increments each cycle. When gap_cnt reaches GAP_TIMEOUT-1 while still invalid:
    - pulse gap_abort_o and set grant_o=0;
    - last_grant = current owner; go to IDLE.
- ACK:
  - req_ready_o=0. Hold tx_valid_o and tx_data_o stable until tx_ready_i.
  - On the accept edge, tx_valid_o=0. Then:
    - if last=1 or burst_cnt==MAX_BURST-1: go to IDLE, burst_cnt=0, last_grant=owner, grant_o=0;
    - else: burst_cnt+1, go to SEND with the same owner.
- Throughput: at most one byte per 2 cycles from the arbiter; in practice it is paced by tx_ready_i.
- Constraints:
  - tx_valid_o never deasserts without an accept, except on reset.
  - Bytes of one packet are never interleaved with another requester unless the burst limit or timeout splits them.
  - req_valid_i changes from non-granted requesters have no effect outside IDLE.
- req_last_i seen on a byte that is also the MAX_BURST-th byte: release once (no double pointer advance).
- gap_cnt and burst_cnt saturate and are cleared on every grant.

Test Plan:
1. After reset, req0 sends 0xA5 with last=1 and tx_ready_i tied high → grant_o=0001 one cycle later; tx_data_o=0xA5 with tx_valid_o for 1 cycle; return to IDLE; busy_o=0.
2. All 4 requesters continuously valid with 1-byte packets → grant order 0,1,2,3,0,1 and tx_data_o matches each source in that order.
3. req1 sends packet 0x11,0x22,0x33(last) while req3 is valid; tx_ready_i delayed 5 cycles per byte → tx_valid_o held stable through the stall; output 0x11,0x22,0x33, then req3's byte.
4. MAX_BURST=4; req0 sends a 6-byte packet 0x01..0x06 while req1 is waiting with 0xF0 → output 01,02,03,04,F0,05,06.
5. req2 sends 0x55 (last=0), then drops valid → after GAP_TIMEOUT cycles gap_abort_o pulses once and grant_o=0; a subsequent req2 valid is granted afresh.
6. Drive RSTN low during ACK with tx_valid_o=1 → tx_valid_o, grant_o and busy_o go to 0 immediately without waiting for a clock; after release, req0 has priority.
